ascii_bin_parser: RTL and testbench

//  Receives a stream of 7-bit ASCII characters, one per valid/ready handshake, and returns one binary number per term.

---
 rtl/ascii_pkg.sv | 19 +
 rtl/ascii_bin_parser_if.sv | 23 ++
 rtl/ascii_char_class.sv | 17 +
 rtl/ascii_bin_parser.sv | 131 +++++++++++++
 tb/tb_ascii_bin_parser.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ascii_pkg.sv
// Shared ASCII constants and parser FSM encoding for the ASCII adder front end.
package ascii_pkg;

  localparam logic [6:0] ASCII_0    = 7'h30;
  localparam logic [6:0] ASCII_9    = 7'h39;
  localparam logic [6:0] ASCII_CR   = 7'h0D;
  localparam logic [6:0] ASCII_SP   = 7'h20;
  localparam logic [6:0] ASCII_PLUS = 7'h2B;
  localparam logic [6:0] ASCII_EQ   = 7'h3D;

  localparam logic [2:0] DIGITS_MAX = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_OUT   = 2'd2
  } state_t;

endpackage

// File: rtl/ascii_bin_parser_if.sv
// Character-in / number-out handshake bundle; slave is the parser, master is its environment.
interface ascii_bin_parser_if #(
  parameter int OUT_W = 8
) ();
  logic [6:0]       char_in;
  logic             char_valid;
  logic             char_ready;
  logic [OUT_W-1:0] num_out;
  logic             num_valid;
  logic             num_ready;
  logic             num_err;
  logic [2:0]       num_digits;

  modport master (
    output char_in, char_valid, num_ready,
    input  char_ready, num_out, num_valid, num_err, num_digits
  );

  modport slave (
    input  char_in, char_valid, num_ready,
    output char_ready, num_out, num_valid, num_err, num_digits
  );
endinterface

// File: rtl/ascii_char_class.sv
// Combinational classifier: decimal digit, number terminator, or anything else.
module ascii_char_class
  import ascii_pkg::*;
(
  input  logic [6:0] char_in,
  output logic       is_digit,
  output logic       is_term,
  output logic [3:0] digit
);
  always_comb begin
    is_digit = (char_in >= ASCII_0) && (char_in <= ASCII_9);
    is_term  = (char_in == ASCII_CR) || (char_in == ASCII_SP) ||
               (char_in == ASCII_PLUS) || (char_in == ASCII_EQ);
    // Digit codes 0x30..0x39 carry their value in the low nibble.
    digit    = is_digit ? char_in[3:0] : 4'd0;
  end
endmodule

// File: rtl/ascii_bin_parser.sv
// Decimal ASCII digit string to saturating unsigned binary, one result per terminated term.
module ascii_bin_parser
  import ascii_pkg::*;
#(
  parameter int OUT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  ascii_bin_parser_if.slave  bus
);
  localparam int               EXT_W   = OUT_W + 4;
  localparam logic [OUT_W-1:0] ACC_MAX = '1;

  state_t           state_q, state_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [OUT_W-1:0] num_out_q, num_out_d;
  logic             num_err_q, num_err_d;
  logic [2:0]       num_digits_q, num_digits_d;

  logic             is_digit, is_term;
  logic [3:0]       digit;
  logic             accept;
  logic [EXT_W-1:0] acc_ext, mac;
  logic             overflow;
  logic [2:0]       cnt_inc;

  ascii_char_class u_class (
    .char_in  (bus.char_in),
    .is_digit (is_digit),
    .is_term  (is_term),
    .digit    (digit)
  );

  assign accept         = bus.char_valid && bus.char_ready;
  assign bus.char_ready = (state_q != ST_OUT) && !rst;
  assign bus.num_valid  = (state_q == ST_OUT);
  assign bus.num_out    = num_out_q;
  assign bus.num_err    = num_err_q;
  assign bus.num_digits = num_digits_q;

  // acc*10+d via shifts; four extra bits hold the worst case (2**OUT_W-1)*10+9.
  always_comb begin
    acc_ext  = {4'd0, acc_q};
    mac      = (acc_ext << 3) + (acc_ext << 1) + {{OUT_W{1'b0}}, digit};
    overflow = mac > {4'd0, ACC_MAX};
    cnt_inc  = (cnt_q == DIGITS_MAX) ? cnt_q : cnt_q + 3'd1;
  end

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    num_out_d    = num_out_q;
    num_err_d    = num_err_q;
    num_digits_d = num_digits_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_digit) begin
            acc_d   = {{(OUT_W-4){1'b0}}, digit};
            cnt_d   = 3'd1;
            state_d = ST_ACCUM;
          end else if (!is_term) begin
            acc_d   = '0;
            err_d   = 1'b1;
            state_d = ST_OUT;
          end
        end
      end
      ST_ACCUM: begin
        if (accept) begin
          if (is_digit) begin
            if (overflow) begin
              acc_d = ACC_MAX;
              err_d = 1'b1;
            end else begin
              acc_d = mac[OUT_W-1:0];
            end
            cnt_d = cnt_inc;
          end else if (is_term) begin
            state_d = ST_OUT;
          end else begin
            acc_d   = '0;
            err_d   = 1'b1;
            state_d = ST_OUT;
          end
        end
      end
      ST_OUT: begin
        if (bus.num_ready) begin
          state_d = ST_IDLE;
          acc_d   = '0;
          cnt_d   = 3'd0;
          err_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Result registers capture the final term state on entry to OUT and hold until then.
    if ((state_d == ST_OUT) && (state_q != ST_OUT)) begin
      num_out_d    = acc_d;
      num_err_d    = err_d;
      num_digits_d = cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      acc_q        <= '0;
      cnt_q        <= 3'd0;
      err_q        <= 1'b0;
      num_out_q    <= '0;
      num_err_q    <= 1'b0;
      num_digits_q <= 3'd0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      num_out_q    <= num_out_d;
      num_err_q    <= num_err_d;
      num_digits_q <= num_digits_d;
    end
  end
endmodule

// File: tb/tb_ascii_bin_parser.sv
// Bench for ascii_bin_parser: directed cases plus randomized terms against a decimal-parse model.
module tb_ascii_bin_parser;
  localparam int OUT_W = 8;
  localparam int MAXV  = 255;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ascii_bin_parser_if #(.OUT_W(OUT_W)) bus ();
  ascii_bin_parser #(.OUT_W(OUT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    int val;
    bit err;
    int dig;
  } res_t;

  res_t exp_q[$];
  res_t last_res;
  int   m_val, m_dig;
  bit   m_in_num;
  int   checks = 0;
  int   errors = 0;
  int   rdy_mode;   // 0 random stalls, 1 hold low, 2 always ready
  bit   mon_en;

  function automatic void chk(string name, longint act, longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endfunction

  function automatic void model_clear();
    m_val    = 0;
    m_dig    = 0;
    m_in_num = 0;
  endfunction

  function automatic void model_push(int v, bit e, int d);
    res_t r;
    r.val = (v > MAXV) ? MAXV : v;
    r.err = e || (v > MAXV);
    r.dig = (d > 7) ? 7 : d;
    exp_q.push_back(r);
    last_res = r;
    model_clear();
  endfunction

  // Decimal value of the digit string; capped well above MAXV so it stays "too big" once it is.
  function automatic void model_char(logic [6:0] c);
    if (c >= 7'h30 && c <= 7'h39) begin
      m_val = m_val * 10 + int'(c - 7'h30);
      if (m_val > 100000) m_val = 100000;
      m_dig++;
      m_in_num = 1;
    end else if (c == 7'h0D || c == 7'h20 || c == 7'h2B || c == 7'h3D) begin
      if (m_in_num) model_push(m_val, 1'b0, m_dig);
    end else begin
      model_push(0, 1'b1, m_dig);
    end
  endfunction

  function automatic void pin(string name, int v, bit e, int d);
    chk({name, "_val"}, last_res.val, v);
    chk({name, "_err"}, last_res.err, e);
    chk({name, "_dig"}, last_res.dig, d);
  endfunction

  task automatic send_char(input logic [6:0] c);
    int guard;
    guard = 0;
    @(negedge clk);
    bus.char_in    = c;
    bus.char_valid = 1'b1;
    while (!bus.char_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.char_ready) begin
      chk("char_ready_timeout", 0, 1);
      bus.char_valid = 1'b0;
      return;
    end
    @(posedge clk);
    model_char(c);
    #1 bus.char_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(7'(s[i]));
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while ((exp_q.size() > 0 || bus.num_valid) && g < 1000) begin
      @(negedge clk);
      #1;
      g++;
    end
    if (g >= 1000) chk("drain_timeout", 0, 1);
  endtask

  function automatic logic [6:0] rand_other();
    logic [6:0] c;
    c = 7'(($urandom_range(0, 127)));
    while ((c >= 7'h30 && c <= 7'h39) || c == 7'h0D || c == 7'h20 || c == 7'h2B || c == 7'h3D)
      c = 7'(($urandom_range(0, 127)));
    return c;
  endfunction

  function automatic logic [6:0] rand_term();
    logic [6:0] t[4];
    t[0] = 7'h0D; t[1] = 7'h20; t[2] = 7'h2B; t[3] = 7'h3D;
    return t[$urandom_range(0, 3)];
  endfunction

  // Consumer: num_ready changes only at falling edges.
  initial begin
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       bus.num_ready = ($urandom_range(0, 2) == 0);
        1:       bus.num_ready = 1'b0;
        default: bus.num_ready = 1'b1;
      endcase
    end
  end

  // Compare process: every cycle, outputs against the head of the expected-result queue.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (mon_en) begin
        chk("num_valid", bus.num_valid, exp_q.size() > 0);
        if (bus.num_valid) begin
          chk("char_ready_out", bus.char_ready, 0);
          if (exp_q.size() > 0) begin
            chk("num_out", bus.num_out, exp_q[0].val);
            chk("num_err", bus.num_err, exp_q[0].err);
            chk("num_digits", bus.num_digits, exp_q[0].dig);
            if (bus.num_ready) void'(exp_q.pop_front());
          end
        end else begin
          chk("char_ready_idle", bus.char_ready, 1);
        end
      end
    end
  end

  initial begin
    #(10 * 80000);
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int nd;
    int n;
    rst            = 1'b1;
    bus.char_in    = 7'h00;
    bus.char_valid = 1'b0;
    bus.num_ready  = 1'b0;
    rdy_mode       = 2;
    mon_en         = 1'b0;
    model_clear();

    #12;
    chk("rst_num_valid", bus.num_valid, 0);
    chk("rst_num_out", bus.num_out, 0);
    chk("rst_num_err", bus.num_err, 0);
    chk("rst_num_digits", bus.num_digits, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_release_char_ready", bus.char_ready, 1);
    mon_en = 1'b1;

    send_str("123\015");  wait_drain(); pin("t123", 123, 0, 3);
    send_str("255+");     wait_drain(); pin("t255", 255, 0, 3);
    send_str("256=");     wait_drain(); pin("t256", 255, 1, 3);
    send_str("9999\015"); wait_drain(); pin("t9999", 255, 1, 4);
    send_str("007 ");     wait_drain(); pin("t007", 7, 0, 3);

    send_char(7'h0D);
    repeat (3) @(negedge clk);
    #1;
    chk("lone_cr_valid", bus.num_valid, 0);
    chk("lone_cr_ready", bus.char_ready, 1);

    send_str("4A");       wait_drain(); pin("t4A", 0, 1, 1);
    send_str("5\015");    wait_drain(); pin("t5", 5, 0, 1);

    rdy_mode = 1;
    send_str("42\015");
    pin("t42", 42, 0, 2);
    repeat (5) @(negedge clk);
    #1;
    chk("hold_valid", bus.num_valid, 1);
    chk("hold_out", bus.num_out, 42);
    chk("hold_char_ready", bus.char_ready, 0);
    rdy_mode = 2;
    wait_drain();
    chk("after_accept_ready", bus.char_ready, 1);
    chk("after_accept_valid", bus.num_valid, 0);

    send_str("99");
    @(negedge clk);
    #2;
    mon_en = 1'b0;
    rst    = 1'b1;
    #1;
    chk("async_rst_num_out", bus.num_out, 0);
    chk("async_rst_num_valid", bus.num_valid, 0);
    chk("async_rst_num_err", bus.num_err, 0);
    chk("async_rst_num_digits", bus.num_digits, 0);
    exp_q.delete();
    model_clear();
    @(posedge clk);
    #3;
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("post_rst_char_ready", bus.char_ready, 1);
    mon_en = 1'b1;
    send_str("5\015");    wait_drain(); pin("t5_after_rst", 5, 0, 1);

    rdy_mode = 0;
    for (n = 0; n < 150; n++) begin
      nd = ($urandom_range(0, 3) == 0) ? $urandom_range(4, 9) : $urandom_range(0, 3);
      for (int k = 0; k < nd; k++) begin
        send_char(7'h30 + 7'($urandom_range(0, 9)));
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      if ($urandom_range(0, 9) == 0) send_char(rand_other());
      else                           send_char(rand_term());
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
